sync_fifo_dpram: RTL

//   Single-clock stream FIFO built around the DPRAM block. It sits between a valid/ready producer and consumer.

---
 rtl/sync_fifo_dpram_pkg.sv | 12 +
 rtl/sync_fifo_dpram_if.sv | 29 ++
 rtl/sync_fifo_dpram_ram.sv | 48 ++++
 rtl/sync_fifo_dpram.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_dpram_pkg.sv
// Shared defaults and sizing helper for the DPRAM-backed stream FIFO.
package sync_fifo_dpram_pkg;

    localparam int DEF_WIDTH = 32'sd8;
    localparam int DEF_DEPTH = 32'sd4;

    // Occupancy counter width: RAM entries plus one in-flight read plus two buffer slots.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 32'sd3);
    endfunction

endpackage

// File: rtl/sync_fifo_dpram_if.sv
// Producer/consumer stream bundle for sync_fifo_dpram; slave is the FIFO side.
interface sync_fifo_dpram_if
    import sync_fifo_dpram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int CW = cnt_width(DEPTH);

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    count;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count
    );

endinterface

// File: rtl/sync_fifo_dpram_ram.sv
// Dual-port RAM with one-cycle registered reads on each port.
// Both write ports are served from clka; this block is only used with clka == clkb.
module sync_fifo_dpram_ram
    import sync_fifo_dpram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clka,
    input  logic                     ena,
    input  logic                     wea,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [WIDTH-1:0]         dina,
    output logic [WIDTH-1:0]         douta,
    input  logic                     clkb,
    input  logic                     enb,
    input  logic                     web,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    input  logic [WIDTH-1:0]         dinb,
    output logic [WIDTH-1:0]         doutb
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write; port A wins if both ports write in the same cycle.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem_r[addra] <= dina;
        end else if (enb && web) begin
            mem_r[addrb] <= dinb;
        end
    end

    // Port A read data register.
    always_ff @(posedge clka) begin
        if (ena && !wea) begin
            douta <= mem_r[addra];
        end
    end

    // Port B read data register.
    always_ff @(posedge clkb) begin
        if (enb && !web) begin
            doutb <= mem_r[addrb];
        end
    end

endmodule

// File: rtl/sync_fifo_dpram.sv
// First-word-fall-through stream FIFO: DPRAM storage plus a two-entry output
// buffer that covers the RAM read latency so one word per clock can flow.
module sync_fifo_dpram
    import sync_fifo_dpram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_dpram_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   RAM_EMPTY = (AW + 1)'(0);
    localparam logic [AW:0]   RAM_FULL  = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      ram_cnt_q, ram_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic [1:0]       ob_cnt_q, ob_cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             alive_q, alive_d;

    logic             s_ready_s;
    logic             m_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             issue_s;
    logic [2:0]       occ_s;
    logic [WIDTH-1:0] ram_doutb_s;

    // alive_q holds s_ready low for the whole reset period and the cycle it is released in.
    assign s_ready_s   = alive_q && (ram_cnt_q != RAM_FULL);
    assign m_valid_s   = (ob_cnt_q != 2'd0);
    assign push_s      = bus.s_valid && s_ready_s;
    assign pop_s       = m_valid_s && bus.m_ready;
    assign occ_s       = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q};
    assign issue_s     = (ram_cnt_q != RAM_EMPTY) && (occ_s < (3'd2 + {2'b00, pop_s}));

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = m_valid_s;
    assign bus.m_data  = head_q;
    assign bus.count   = CW'(ram_cnt_q) + CW'(rd_pend_q) + CW'(ob_cnt_q);

    sync_fifo_dpram_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clka  (clk),
        .ena   (push_s),
        .wea   (push_s),
        .addra (wptr_q),
        .dina  (bus.s_data),
        .douta (),
        .clkb  (clk),
        .enb   (issue_s),
        .web   (1'b0),
        .addrb (rptr_q),
        .dinb  ({WIDTH{1'b0}}),
        .doutb (ram_doutb_s)
    );

    // Pointer, RAM occupancy and read-issue next state.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        rd_pend_d = issue_s;
        alive_d   = 1'b1;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (issue_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, issue_s})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    // Output buffer: RAM data lands in the first free slot; a pop shifts tail into head.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        ob_cnt_d = ob_cnt_q;
        case ({rd_pend_q, pop_s})
            2'b11: begin
                if (ob_cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = ram_doutb_s;
                end else begin
                    head_d = ram_doutb_s;
                end
            end
            2'b10: begin
                if (ob_cnt_q == 2'd0) begin
                    head_d   = ram_doutb_s;
                    ob_cnt_d = 2'd1;
                end else begin
                    tail_d   = ram_doutb_s;
                    ob_cnt_d = 2'd2;
                end
            end
            2'b01: begin
                head_d   = tail_q;
                ob_cnt_d = ob_cnt_q - 2'd1;
            end
            default: begin
                ob_cnt_d = ob_cnt_q;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q    <= {AW{1'b0}};
            rptr_q    <= {AW{1'b0}};
            ram_cnt_q <= RAM_EMPTY;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
            head_q    <= {WIDTH{1'b0}};
            tail_q    <= {WIDTH{1'b0}};
            alive_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pend_q <= rd_pend_d;
            ob_cnt_q  <= ob_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            alive_q   <= alive_d;
        end
    end

endmodule
